temp_ascii_formatter: RTL and testbench

Sits between the I2C temperature-read stage and the UART transmitter in the sensor hub. It accepts one temperature byte per transaction and converts it to decimal ASCII with a sequential subtractor. It then streams the message "Temp = <value><EOL>" byte-by-byte to the UART TX over a valid/ready handshake. Example: 0x19 produces "Temp = 25\r\n", which is 11 bytes.

---
 rtl/temp_ascii_formatter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_temp_ascii_formatter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_ascii_formatter.sv
// Converts one captured temperature byte to decimal ASCII with repeated subtraction,
// then streams "Temp = <value><EOL>" to a UART transmitter over valid/ready.
module temp_ascii_formatter #(
  parameter bit SIGNED_IN = 1'b1,
  parameter bit EOL_CRLF  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       temp_valid,
  input  logic [7:0] temp_data,
  output logic       temp_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       msg_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_T = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;

  logic       neg_r;
  logic [7:0] rem_r;
  logic [1:0] hund_r;
  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic [3:0] idx_r;

  logic       neg_s;
  logic [7:0] mag_s;
  logic       xfer_s;
  logic [3:0] len_s;
  logic       last_s;

  logic [7:0] tx_data_s;
  logic       tx_valid_s;
  logic       msg_done_s;
  logic       busy_s;
  logic       temp_ready_s;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Prefix(7) + ones(1) + LF(1), plus optional sign, hundreds, tens and CR.
  function automatic logic [3:0] msg_length(input logic       neg,
                                            input logic [1:0] h,
                                            input logic [3:0] t);
    logic h_nz;
    logic t_nz;
    logic [3:0] len;
    h_nz = (h != 2'd0);
    t_nz = h_nz | (t != 4'd0);
    len  = 4'd9 + {3'd0, neg} + {3'd0, h_nz} + {3'd0, t_nz} + (EOL_CRLF ? 4'd1 : 4'd0);
    return len;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic       neg,
                                          input logic [1:0] h,
                                          input logic [3:0] t,
                                          input logic [3:0] o);
    logic       h_nz;
    logic       t_nz;
    logic [3:0] k;
    logic [7:0] b;
    h_nz = (h != 2'd0);
    t_nz = h_nz | (t != 4'd0);
    k    = 4'd0;
    b    = 8'h00;
    case (idx)
      4'd0:    b = 8'h54;
      4'd1:    b = 8'h65;
      4'd2:    b = 8'h6D;
      4'd3:    b = 8'h70;
      4'd4:    b = 8'h20;
      4'd5:    b = 8'h3D;
      4'd6:    b = 8'h20;
      default: begin
        // Walk the optional fields, consuming one slot for each one present.
        k = idx - 4'd7;
        if (neg && (k == 4'd0)) begin
          b = 8'h2D;
        end else begin
          k = k - {3'd0, neg};
          if (h_nz && (k == 4'd0)) begin
            b = ascii_digit({2'b00, h});
          end else begin
            k = k - {3'd0, h_nz};
            if (t_nz && (k == 4'd0)) begin
              b = ascii_digit(t);
            end else begin
              k = k - {3'd0, t_nz};
              if (k == 4'd0) begin
                b = ascii_digit(o);
              end else if (k == 4'd1) begin
                b = EOL_CRLF ? 8'h0D : 8'h0A;
              end else begin
                b = 8'h0A;
              end
            end
          end
        end
      end
    endcase
    return b;
  endfunction

  // Capture-side magnitude and handshake decode.
  always_comb begin
    neg_s  = SIGNED_IN & temp_data[7];
    mag_s  = neg_s ? (~temp_data + 8'd1) : temp_data;
    xfer_s = tx_valid & tx_ready;
    len_s  = msg_length(neg_r, hund_r, tens_r);
    last_s = (idx_r == (len_s - 4'd1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (temp_valid) begin
          state_s = CONV_H;
        end else begin
          state_s = IDLE;
        end
      end
      CONV_H: begin
        if (rem_r >= 8'd100) begin
          state_s = CONV_H;
        end else begin
          state_s = CONV_T;
        end
      end
      CONV_T: begin
        if (rem_r >= 8'd10) begin
          state_s = CONV_T;
        end else begin
          state_s = SEND;
        end
      end
      SEND: begin
        if (xfer_s && last_s) begin
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; the first byte is loaded as SEND is entered.
  always_comb begin
    tx_data_s    = 8'h00;
    tx_valid_s   = 1'b0;
    msg_done_s   = 1'b0;
    busy_s       = (state_s != IDLE);
    temp_ready_s = (state_s == IDLE);
    case (state_r)
      IDLE: begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
      end
      CONV_H: begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
      end
      CONV_T: begin
        if (rem_r < 8'd10) begin
          tx_data_s  = msg_byte(4'd0, neg_r, hund_r, tens_r, rem_r[3:0]);
          tx_valid_s = 1'b1;
        end else begin
          tx_data_s  = 8'h00;
          tx_valid_s = 1'b0;
        end
      end
      SEND: begin
        if (xfer_s) begin
          if (last_s) begin
            tx_data_s  = 8'h00;
            tx_valid_s = 1'b0;
            msg_done_s = 1'b1;
          end else begin
            tx_data_s  = msg_byte(idx_r + 4'd1, neg_r, hund_r, tens_r, ones_r);
            tx_valid_s = 1'b1;
          end
        end else begin
          tx_data_s  = tx_data;
          tx_valid_s = tx_valid;
        end
      end
      default: begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      msg_done   <= 1'b0;
      busy       <= 1'b0;
      temp_ready <= 1'b1;
    end else begin
      tx_data    <= tx_data_s;
      tx_valid   <= tx_valid_s;
      msg_done   <= msg_done_s;
      busy       <= busy_s;
      temp_ready <= temp_ready_s;
    end
  end

  // Capture, sequential subtractor and byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_r  <= 1'b0;
      rem_r  <= 8'd0;
      hund_r <= 2'd0;
      tens_r <= 4'd0;
      ones_r <= 4'd0;
      idx_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (temp_valid) begin
            neg_r  <= neg_s;
            rem_r  <= mag_s;
            hund_r <= 2'd0;
            tens_r <= 4'd0;
            idx_r  <= 4'd0;
          end
        end
        CONV_H: begin
          if (rem_r >= 8'd100) begin
            rem_r  <= rem_r - 8'd100;
            hund_r <= hund_r + 2'd1;
          end
        end
        CONV_T: begin
          if (rem_r >= 8'd10) begin
            rem_r  <= rem_r - 8'd10;
            tens_r <= tens_r + 4'd1;
          end else begin
            ones_r <= rem_r[3:0];
            idx_r  <= 4'd0;
          end
        end
        SEND: begin
          if (xfer_s && !last_s) begin
            idx_r <= idx_r + 4'd1;
          end
        end
        default: begin
          idx_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Scoreboard bench: three formatter instances (signed/CRLF, unsigned/CRLF, signed/LF)
// receive the same temperature bytes; a negedge monitor pops and compares every byte.
module tb_temp_ascii_formatter;

  logic       clk;
  logic       rst;
  logic       temp_valid;
  logic [7:0] temp_data;
  logic       tx_ready;
  logic       rdy_cmd;
  logic       bp_en;
  int         bp_cnt;
  int         bp_seen;

  logic       temp_ready0, temp_ready1, temp_ready2;
  logic [7:0] tx_data0, tx_data1, tx_data2;
  logic       tx_valid0, tx_valid1, tx_valid2;
  logic       busy0, busy1, busy2;
  logic       msg_done0, msg_done1, msg_done2;

  logic [7:0] q[3][$];
  int         exp_done[3];
  int         done_cnt[3];
  int         xfer_cnt[3];
  logic       hold_pend[3];
  logic [7:0] held[3];

  int errors;
  int checks;

  temp_ascii_formatter #(.SIGNED_IN(1'b1), .EOL_CRLF(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_data(temp_data),
    .temp_ready(temp_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .busy(busy0), .msg_done(msg_done0));

  temp_ascii_formatter #(.SIGNED_IN(1'b0), .EOL_CRLF(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_data(temp_data),
    .temp_ready(temp_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .busy(busy1), .msg_done(msg_done1));

  temp_ascii_formatter #(.SIGNED_IN(1'b1), .EOL_CRLF(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_data(temp_data),
    .temp_ready(temp_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .busy(busy2), .msg_done(msg_done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: after each accepted byte, tx_ready stays low for a few cycles.
  always_comb tx_ready = bp_en ? (bp_cnt == 0) : rdy_cmd;

  initial begin
    bp_cnt  = 0;
    bp_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (xfer_cnt[0] != bp_seen) begin
        bp_seen = xfer_cnt[0];
        if (bp_en) bp_cnt = 3 + (xfer_cnt[0] % 5);
      end else if (bp_cnt > 0) begin
        bp_cnt = bp_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [7:0] d,
                     input logic md, input logic bz);
    logic [7:0] e;
    if (rst) begin
      hold_pend[k] = 1'b0;
    end else begin
      if (hold_pend[k]) begin
        checks++;
        if (v !== 1'b1 || d !== held[k]) begin
          errors++;
          $display("FAIL hold dut%0d: got valid=%b data=%h, want valid=1 data=%h", k, v, d, held[k]);
        end
      end
      hold_pend[k] = (v === 1'b1) && (tx_ready === 1'b0);
      held[k]      = d;
      if (v === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        xfer_cnt[k]++;
        if (q[k].size() == 0) begin
          errors++;
          $display("FAIL byte dut%0d: got unexpected %h, want none", k, d);
        end else begin
          e = q[k].pop_front();
          if (d !== e) begin
            errors++;
            $display("FAIL byte dut%0d: got %h, want %h", k, d, e);
          end
        end
      end
      if (md === 1'b1) begin
        checks++;
        done_cnt[k]++;
        if (q[k].size() != 0 || bz !== 1'b0) begin
          errors++;
          $display("FAIL done dut%0d: got pending=%0d busy=%b, want pending=0 busy=0", k, q[k].size(), bz);
        end
      end
    end
  endtask

  // Monitor: outputs sampled mid-cycle, transfers recognised ahead of their edge.
  always @(negedge clk) begin
    mon(0, tx_valid0, tx_data0, msg_done0, busy0);
    mon(1, tx_valid1, tx_data1, msg_done1, busy1);
    mon(2, tx_valid2, tx_data2, msg_done2, busy2);
  end

  task automatic push_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) q[k].push_back(s[i]);
  endtask

  task automatic send(input logic [7:0] d, input string vs, input string vu);
    push_str(0, {"Temp = ", vs}); q[0].push_back(8'h0D); q[0].push_back(8'h0A);
    push_str(1, {"Temp = ", vu}); q[1].push_back(8'h0D); q[1].push_back(8'h0A);
    push_str(2, {"Temp = ", vs}); q[2].push_back(8'h0A);
    for (int k = 0; k < 3; k++) exp_done[k]++;
    temp_data  = d;
    temp_valid = 1'b1;
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
    temp_data  = ~d;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy0 || busy1 || busy2 || q[0].size() != 0 || q[1].size() != 0 ||
            q[2].size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, want idle", n);
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vec_data[8];
  string      vec_s[8];
  string      vec_u[8];

  initial begin
    int n;
    int base;
    errors = 0;
    checks = 0;
    for (int k = 0; k < 3; k++) begin
      exp_done[k] = 0; done_cnt[k] = 0; xfer_cnt[k] = 0; hold_pend[k] = 1'b0; held[k] = 8'h00;
    end
    vec_data[0] = 8'h80; vec_s[0] = "-128"; vec_u[0] = "128";
    vec_data[1] = 8'hFF; vec_s[1] = "-1";   vec_u[1] = "255";
    vec_data[2] = 8'h7F; vec_s[2] = "127";  vec_u[2] = "127";
    vec_data[3] = 8'h00; vec_s[3] = "0";    vec_u[3] = "0";
    vec_data[4] = 8'h64; vec_s[4] = "100";  vec_u[4] = "100";
    vec_data[5] = 8'h0A; vec_s[5] = "10";   vec_u[5] = "10";
    vec_data[6] = 8'hF6; vec_s[6] = "-10";  vec_u[6] = "246";
    vec_data[7] = 8'h9C; vec_s[7] = "-100"; vec_u[7] = "156";

    rst = 1'b1; temp_valid = 1'b0; temp_data = 8'h00; rdy_cmd = 1'b1; bp_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid0, 0);
    chk("rst_tx_data", tx_data0, 8'h00);
    chk("rst_busy", busy0, 0);
    chk("rst_msg_done", msg_done0, 0);
    chk("rst_temp_ready", temp_ready0, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 25 decimal: first byte four cycles after capture.
    send(8'h19, "25", "25");
    chk("cap_busy", busy0, 1);
    chk("cap_temp_ready", temp_ready0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_valid_early", tx_valid0, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", tx_valid0, 1);
    chk("lat_first_byte", tx_data0, 8'h54);
    wait_idle(200);

    for (int i = 0; i < 8; i++) begin
      send(vec_data[i], vec_s[i], vec_u[i]);
      wait_idle(200);
    end

    // Backpressure, with an ignored capture request mid-message.
    bp_en = 1'b1;
    send(8'h19, "25", "25");
    repeat (20) @(posedge clk);
    #1;
    chk("bp_busy_mid", busy0, 1);
    temp_data  = 8'h05;
    temp_valid = 1'b1;
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
    wait_idle(600);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_no_second_valid", tx_valid0, 0);
    chk("bp_no_second_busy", busy0, 0);
    bp_en = 1'b0;
    rdy_cmd = 1'b1;

    // Reset right after the fourth byte transfers.
    base = xfer_cnt[0];
    send(8'h19, "25", "25");
    n = 0;
    while (xfer_cnt[0] < base + 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("rst_mid_reached", (n < 50) ? 1 : 0, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", tx_valid0, 0);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_tx_data", tx_data0, 8'h00);
    chk("rst_mid_temp_ready", temp_ready0, 1);
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      exp_done[k]--;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h19, "25", "25");
    wait_idle(200);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("done_count_dut%0d", k), done_cnt[k], exp_done[k]);
      chk($sformatf("leftover_dut%0d", k), q[k].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
